// File: rtl/timer_sched_pkg.sv
// timer_sched shared types and configuration.
// CSR operand types, block address map and scheduler states.
package timer_sched_pkg;

   typedef logic [31:0] word;
   typedef logic [4:0]  r;
   typedef logic [11:0] CsrAddrT;

   typedef enum logic [2:0] {
      CSR_NONE = 3'b000,
      CSRRW    = 3'b001,
      CSRRS    = 3'b010,
      CSRRC    = 3'b011,
      CSRRWI   = 3'b101,
      CSRRSI   = 3'b110,
      CSRRCI   = 3'b111
   } csr_op_t;

   localparam CsrAddrT TimerSchedCsrBase = 12'h7C0;
   localparam int      TimerSchedSlots   = 4;

   typedef logic [1:0] SchedStateT;

   localparam SchedStateT ST_IDLE  = 2'd0;
   localparam SchedStateT ST_SCAN  = 2'd1;
   localparam SchedStateT ST_WATCH = 2'd2;

endpackage

// File: rtl/timer_sched_scan.sv
// Sequential wrap-aware minimum finder over armed deadlines.
// One slot per cycle; the last slot is merged combinationally.
module timer_sched_scan
   import timer_sched_pkg::*;
#(
   parameter int NumSlots = TimerSchedSlots,
   parameter int IdxW     = $clog2(NumSlots)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_start,
   input  logic [NumSlots-1:0] i_armed,
   input  word                 i_deadline [NumSlots],
   output logic                o_done,
   output logic                o_valid,
   output logic [IdxW-1:0]     o_idx,
   output word                 o_deadline
);

   logic            r_busy;
   logic            r_found;
   logic [IdxW-1:0] r_idx;
   logic [IdxW-1:0] r_best_idx;
   word             r_best_dl;

   word             w_dl;
   word             w_diff;
   logic            w_cand;
   logic            w_last;

   // strict less-than keeps the lowest index on ties
   assign w_dl       = i_deadline[r_idx];
   assign w_diff     = w_dl - r_best_dl;
   assign w_cand     = i_armed[r_idx] &&
                       (!r_found || $signed(w_diff) < 0);
   assign w_last     = r_busy &&
                       (r_idx == IdxW'(NumSlots - 1));
   assign o_done     = w_last;
   assign o_valid    = r_found || w_cand;
   assign o_idx      = w_cand ? r_idx : r_best_idx;
   assign o_deadline = w_cand ? w_dl : r_best_dl;

   // walk slots, tracking the earliest armed deadline so far
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_busy     <= 1'b0;
         r_found    <= 1'b0;
         r_idx      <= '0;
         r_best_idx <= '0;
         r_best_dl  <= '0;
      end else if (i_start) begin
         r_busy  <= 1'b1;
         r_found <= 1'b0;
         r_idx   <= '0;
      end else if (r_busy) begin
         if (w_cand) begin
            r_found    <= 1'b1;
            r_best_idx <= r_idx;
            r_best_dl  <= w_dl;
         end
         if (w_last) begin
            r_busy <= 1'b0;
         end else begin
            r_idx <= r_idx + 1'b1;
         end
      end
   end

endmodule

// File: rtl/timer_sched.sv
// Deadline scheduler sharing one monotonic timer among slots.
// CSR decode, deadline/mask storage and the IDLE/SCAN/WATCH FSM.
module timer_sched
   import timer_sched_pkg::*;
#(
   parameter int      NumSlots = TimerSchedSlots,
   parameter CsrAddrT CsrBase  = TimerSchedCsrBase
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                csr_enable,
   input  CsrAddrT             csr_addr,
   input  csr_op_t             csr_op,
   input  r                    rs1_zimm,
   input  word                 rs1_data,
   input  word                 mono_timer,
   output logic [NumSlots-1:0] pend,
   output word                 csr_out
);

   localparam int      IdxW    = $clog2(NumSlots);
   localparam CsrAddrT MaskOff = CsrAddrT'(NumSlots);
   localparam CsrAddrT StatOff = CsrAddrT'(NumSlots + 1);

   word                 r_dl [NumSlots];
   logic [NumSlots-1:0] r_mask;
   logic [NumSlots-1:0] r_pend;
   SchedStateT          r_state;
   logic                r_valid;
   logic [IdxW-1:0]     r_best_idx;
   word                 r_best_dl;

   CsrAddrT             w_off;
   logic [IdxW-1:0]     w_slot;
   logic                w_is_dl;
   logic                w_is_mask;
   logic                w_wr;
   logic                w_imm;
   logic                w_rw;
   word                 w_src;
   logic [NumSlots-1:0] w_srcm;
   word                 w_old;
   word                 w_new;
   logic [NumSlots-1:0] w_mask_n;
   word                 w_diff;
   logic                w_expired;
   logic                w_tgt;
   logic                w_fire;
   logic                w_start;
   SchedStateT          w_state_n;
   logic                w_done;
   logic                w_sc_valid;
   logic [IdxW-1:0]     w_sc_idx;
   word                 w_sc_dl;

   assign w_off     = csr_addr - CsrBase;
   assign w_slot    = w_off[IdxW-1:0];
   assign w_is_dl   = csr_enable && (w_off < MaskOff);
   assign w_is_mask = csr_enable && (w_off == MaskOff);
   assign w_wr      = w_is_dl || w_is_mask;

   assign w_imm = (csr_op == CSRRWI) || (csr_op == CSRRSI) ||
                  (csr_op == CSRRCI);
   assign w_rw  = (csr_op == CSRRW) || (csr_op == CSRRWI);
   assign w_src = w_imm ? {27'b0, rs1_zimm} : rs1_data;
   assign w_srcm = w_src[NumSlots-1:0];

   // pre-write read value of the addressed register
   always_comb begin
      w_old = '0;
      if (w_off < MaskOff) begin
         w_old = r_dl[w_slot];
      end else if (w_off == MaskOff) begin
         w_old = 32'(r_mask);
      end else if (w_off == StatOff) begin
         w_old = {22'b0, r_state, 4'(r_best_idx),
                  3'b0, r_valid};
      end
   end

   assign csr_out = w_old;

   // CSR read-modify-write result
   always_comb begin
      case (csr_op)
         CSRRW, CSRRWI: w_new = w_src;
         CSRRS, CSRRSI: w_new = w_old | w_src;
         CSRRC, CSRRCI: w_new = w_old & ~w_src;
         default:       w_new = w_old;
      endcase
   end

   // wrap-aware expiry; a write aimed at the winner suppresses it
   assign w_diff    = mono_timer - r_best_dl;
   assign w_expired = (r_state == ST_WATCH) &&
                      ($signed(w_diff) >= 0);
   assign w_tgt     = (w_is_dl && (w_slot == r_best_idx)) ||
                      (w_is_mask && (w_rw || w_srcm[r_best_idx]));
   assign w_fire    = w_expired && !w_tgt;
   assign w_start   = w_wr || w_fire;

   // next armed mask: write, deadline arm, expiry disarm
   always_comb begin
      w_mask_n = r_mask;
      if (w_is_mask) begin
         w_mask_n = w_new[NumSlots-1:0];
      end
      if (w_is_dl) begin
         w_mask_n[w_slot] = 1'b1;
      end
      if (w_fire) begin
         w_mask_n[r_best_idx] = 1'b0;
      end
   end

   // FSM next state
   always_comb begin
      w_state_n = r_state;
      if (w_start) begin
         w_state_n = ST_SCAN;
      end else if ((r_state == ST_SCAN) && w_done) begin
         w_state_n = w_sc_valid ? ST_WATCH : ST_IDLE;
      end
   end

   // deadline and mask registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < NumSlots; k++) begin
            r_dl[k] <= '0;
         end
         r_mask <= '0;
      end else begin
         if (w_is_dl) begin
            r_dl[w_slot] <= w_new;
         end
         r_mask <= w_mask_n;
      end
   end

   // state, latched winner and registered pend pulse
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_valid    <= 1'b0;
         r_best_idx <= '0;
         r_best_dl  <= '0;
         r_pend     <= '0;
      end else begin
         r_state <= w_state_n;
         r_pend  <= '0;
         if (w_fire) begin
            r_pend[r_best_idx] <= 1'b1;
         end
         if (w_start) begin
            r_valid <= 1'b0;
         end else if ((r_state == ST_SCAN) && w_done) begin
            r_valid    <= w_sc_valid;
            r_best_idx <= w_sc_idx;
            r_best_dl  <= w_sc_dl;
         end
      end
   end

   assign pend = r_pend;

   timer_sched_scan #(
      .NumSlots (NumSlots),
      .IdxW     (IdxW)
   ) u_scan (
      .clk        (clk),
      .reset      (reset),
      .i_start    (w_start),
      .i_armed    (r_mask),
      .i_deadline (r_dl),
      .o_done     (w_done),
      .o_valid    (w_sc_valid),
      .o_idx      (w_sc_idx),
      .o_deadline (w_sc_dl)
   );

endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched.
// Expected pend pulses are queued at stimulus time and popped on output.
module tb_timer_sched;
   import timer_sched_pkg::*;

   localparam CsrAddrT B = TimerSchedCsrBase;

   typedef struct {
      logic [3:0]  slots;
      logic [31:0] t;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       csr_enable;
   CsrAddrT    csr_addr;
   csr_op_t    csr_op;
   r           rs1_zimm;
   word        rs1_data;
   word        mono_timer;
   logic [3:0] pend;
   word        csr_out;

   logic       ld;
   word        ld_val;

   exp_t       exp_q[$];
   int         total;
   int         bad;

   timer_sched #(
      .NumSlots (4),
      .CsrBase  (TimerSchedCsrBase)
   ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .csr_enable (csr_enable),
      .csr_addr   (csr_addr),
      .csr_op     (csr_op),
      .rs1_zimm   (rs1_zimm),
      .rs1_data   (rs1_data),
      .mono_timer (mono_timer),
      .pend       (pend),
      .csr_out    (csr_out)
   );

   // free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // monotonic timer model, loadable
   always @(posedge clk) begin
      if (ld) mono_timer <= ld_val;
      else    mono_timer <= mono_timer + 1;
   end

   // scoreboard: every pend pulse must match the queue head
   always @(negedge clk) begin
      exp_t e;
      if (pend !== 4'b0000) begin
         total++;
         assert (exp_q.size() > 0) else begin
            bad++;
            $error("FAIL pend_unexp obs=%b mono=%0d exp=none",
                   pend, mono_timer);
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            assert (pend === e.slots && mono_timer === e.t)
            else begin
               bad++;
               $error("FAIL pend obs=%b@%0d exp=%b@%0d",
                      pend, mono_timer, e.slots, e.t);
            end
         end
      end
   end

   function automatic CsrAddrT adr(input int k);
      return B + CsrAddrT'(k);
   endfunction

   task automatic load(input word v);
      ld     = 1'b1;
      ld_val = v;
      @(posedge clk);
      #1;
      ld     = 1'b0;
   endtask

   task automatic wr(input CsrAddrT a, input csr_op_t op,
                     input word v);
      csr_addr   = a;
      csr_op     = op;
      rs1_data   = v;
      rs1_zimm   = v[4:0];
      csr_enable = 1'b1;
      @(posedge clk);
      #1;
      csr_enable = 1'b0;
   endtask

   task automatic rd(input CsrAddrT a, input word msk,
                     input word exp, input string tag);
      csr_enable = 1'b0;
      csr_addr   = a;
      #1;
      total++;
      assert ((csr_out & msk) === exp) else begin
         bad++;
         $error("FAIL %s obs=%h exp=%h", tag, csr_out & msk, exp);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_mono(input word v);
      int n;
      n = 0;
      while (mono_timer !== v && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      total++;
      assert (mono_timer === v) else begin
         bad++;
         $error("FAIL wait_mono obs=%0d exp=%0d", mono_timer, v);
      end
   endtask

   task automatic drain(input int lim, input string tag);
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < lim) begin
         @(posedge clk);
         #1;
         n++;
      end
      total++;
      assert (exp_q.size() == 0) else begin
         bad++;
         $error("FAIL %s left=%0d exp=0", tag, exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      reset      = 1'b0;
      csr_enable = 1'b0;
      csr_addr   = B;
      csr_op     = CSRRW;
      rs1_zimm   = '0;
      rs1_data   = '0;
      ld         = 1'b1;
      ld_val     = '0;
      mono_timer = '0;
      repeat (3) @(posedge clk);
      #1;
      ld    = 1'b0;
      reset = 1'b1;

      // reset state of every block register
      for (int k = 0; k < 6; k++) begin
         rd(adr(k), 32'hFFFF_FFFF, 32'h0, "rst_reg");
      end
      rd(adr(6), 32'hFFFF_FFFF, 32'h0, "rd_outside_hi");
      rd(B - 12'd1, 32'hFFFF_FFFF, 32'h0, "rd_outside_lo");
      repeat (100) @(posedge clk);
      #1;
      total++;
      assert (pend === 4'b0000) else begin
         bad++;
         $error("FAIL idle_pend obs=%b exp=0000", pend);
      end

      // single slot, scan latency and one-cycle pend
      load(32'd0);
      wr(adr(2), CSRRW, 32'd50);
      exp_q.push_back('{slots: 4'b0100, t: 32'd51});
      rd(adr(5), 32'h0000_0300, 32'h0000_0100, "st_scan0");
      repeat (2) @(posedge clk);
      #1;
      rd(adr(5), 32'h0000_0300, 32'h0000_0100, "st_scan3");
      rd(adr(5), 32'hFFFF_FFFF, 32'h0000_0221, "st_watch");
      drain(200, "t1_drain");
      rd(adr(4), 32'hFFFF_FFFF, 32'h0, "t1_mask");
      rd(adr(2), 32'hFFFF_FFFF, 32'd50, "t1_dl_kept");

      // ordering, tie break and back-to-back spacing
      load(32'd0);
      wr(adr(0), CSRRW, 32'd200);
      wr(adr(1), CSRRW, 32'd100);
      wr(adr(3), CSRRS, 32'd100);
      exp_q.push_back('{slots: 4'b0010, t: 32'd101});
      exp_q.push_back('{slots: 4'b1000, t: 32'd106});
      exp_q.push_back('{slots: 4'b0001, t: 32'd201});
      rd(adr(3), 32'hFFFF_FFFF, 32'd100, "t2_rs");
      drain(400, "t2_drain");
      rd(adr(4), 32'hFFFF_FFFF, 32'h0, "t2_mask");

      // timer wrap
      load(32'hFFFF_FFF0);
      wr(adr(0), CSRRW, 32'h0000_0010);
      exp_q.push_back('{slots: 4'b0001, t: 32'h0000_0011});
      drain(200, "t3_drain");

      // same-cycle expiry with an unrelated write
      load(32'd590);
      wr(adr(2), CSRRW, 32'd600);
      wait_mono(32'd600);
      wr(adr(0), CSRRW, 32'd700);
      exp_q.push_back('{slots: 4'b0100, t: 32'd601});
      exp_q.push_back('{slots: 4'b0001, t: 32'd701});
      drain(300, "t4_drain");

      // disarm in the expiry cycle wins over the pend
      load(32'd290);
      wr(adr(1), CSRRW, 32'd300);
      wait_mono(32'd300);
      wr(adr(4), CSRRCI, 32'd2);
      repeat (8) @(posedge clk);
      #1;
      rd(adr(5), 32'h0000_0301, 32'h0, "t5_status");
      rd(adr(4), 32'hFFFF_FFFF, 32'h0, "t5_mask");
      rd(adr(1), 32'hFFFF_FFFF, 32'd300, "t5_dl_kept");

      // async reset mid-watch
      load(32'd390);
      wr(adr(0), CSRRW, 32'd500);
      wait_mono(32'd400);
      reset = 1'b0;
      #1;
      total++;
      assert (pend === 4'b0000) else begin
         bad++;
         $error("FAIL rst_pend obs=%b exp=0000", pend);
      end
      rd(adr(0), 32'hFFFF_FFFF, 32'h0, "t6_dl");
      rd(adr(4), 32'hFFFF_FFFF, 32'h0, "t6_mask");
      rd(adr(5), 32'hFFFF_FFFF, 32'h0, "t6_status");
      reset = 1'b1;
      wait_mono(32'd520);
      rd(adr(5), 32'hFFFF_FFFF, 32'h0, "t6_status_end");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
